// File: rtl/ysyx_25040129_rd_responder.sv
// Read-channel subordinate: single outstanding AR, programmable response latency,
// word-addressed on-chip array with a byte-strobed backdoor write port.
module ysyx_25040129_rd_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [2:0]  arsize,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic        bd_wen,
    input  logic [31:0] bd_waddr,
    input  logic [31:0] bd_wdata,
    input  logic [3:0]  bd_wstrb
);

    // state  | meaning
    // S_IDLE | ready for a new AR request
    // S_WAIT | counting down the response latency
    // S_RESP | presenting rvalid until rready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        arready_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        load;

    logic [31:0] rd_off, wr_off;
    logic [AW-1:0] rd_idx, wr_idx;
    logic        rd_decerr, rd_slverr;
    logic [31:0] rd_word;
    logic [1:0]  rd_resp;

    // Full-width range compare keeps the 32-bit wrap semantics of the offset.
    assign rd_off    = araddr - BASE_ADDR;
    assign wr_off    = bd_waddr - BASE_ADDR;
    assign rd_idx    = rd_off[AW+1:2];
    assign wr_idx    = wr_off[AW+1:2];
    assign rd_decerr = (rd_off >= SPAN);
    assign rd_slverr = (arsize > 3'd2)
                     || ((arsize == 3'd1) && araddr[0])
                     || ((arsize == 3'd2) && (araddr[1:0] != 2'b00));

    always_comb begin
        rd_word = 32'h0;
        rd_resp = RESP_OKAY;
        if (rd_decerr) begin
            rd_resp = RESP_DECERR;
        end else if (rd_slverr) begin
            rd_resp = RESP_SLVERR;
        end else begin
            rd_word = mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst && bd_wen && (wr_off < SPAN)) begin
            for (int b = 0; b < 4; b++) begin
                if (bd_wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= bd_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arvalid && arready_q) begin
                    load = 1'b1;
                    if (LAT == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end
            end
            S_RESP: begin
                if (rready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rdata/rresp are captured only on the handshake, so later backdoor
    // writes to the same word cannot disturb a pending response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            arready_q <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arready_q <= (state_d == S_IDLE);
            if (load) begin
                rdata_q <= rd_word;
                rresp_q <= rd_resp;
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = (state_q == S_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_ysyx_25040129_rd_responder.sv
// Directed bench: vector table of single reads plus hand-written sequences for
// backpressure, backdoor ordering, mid-wait reset and zero-latency timing.
module tb_ysyx_25040129_rd_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic [2:0]  arsize;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        bd_wen;
    logic [31:0] bd_waddr;
    logic [31:0] bd_wdata;
    logic [3:0]  bd_wstrb;

    logic        arvalid1, rready1, arready1, rvalid1;
    logic [31:0] rdata1;
    logic [1:0]  rresp1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_25040129_rd_responder #(
        .BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(2)
    ) u_dut (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arsize(arsize),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .bd_wen(bd_wen), .bd_waddr(bd_waddr), .bd_wdata(bd_wdata), .bd_wstrb(bd_wstrb)
    );

    ysyx_25040129_rd_responder #(
        .BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid1), .arsize(arsize),
        .arready(arready1), .rdata(rdata1), .rresp(rresp1), .rvalid(rvalid1), .rready(rready1),
        .bd_wen(bd_wen), .bd_waddr(bd_waddr), .bd_wdata(bd_wdata), .bd_wstrb(bd_wstrb)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        bd_wen = 1'b1; bd_waddr = a; bd_wdata = d; bd_wstrb = s;
        @(posedge clk); #1;
        bd_wen = 1'b0;
    endtask

    // Handshake in cycle T; lat counts cycles after T until rvalid is seen.
    task automatic ar_read(input logic [31:0] a, input logic [2:0] s,
                           input logic bw, input logic [31:0] bd,
                           output logic [31:0] d, output logic [1:0] r, output int lat,
                           output logic hs_rdy, output logic ar_after, output logic rv_after);
        d = 32'h0; r = 2'b00; lat = 0;
        @(posedge clk); #1;
        araddr = a; arsize = s; arvalid = 1'b1; rready = 1'b1;
        bd_wen = bw; bd_waddr = a; bd_wdata = bd; bd_wstrb = 4'hF;
        @(negedge clk);
        hs_rdy = arready;
        @(posedge clk); #1;
        arvalid = 1'b0; bd_wen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rvalid) begin
                lat = i; d = rdata; r = rresp;
                break;
            end
        end
        @(negedge clk);
        ar_after = arready;
        rv_after = rvalid;
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        hs, ara, rva, seen, quiet;

    initial begin
        vecs[0]  = '{32'h8000_0000, 3'd2, 32'hDEAD_BEEF, 2'b00};
        vecs[1]  = '{32'h8000_0002, 3'd1, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{32'h8000_0001, 3'd1, 32'h0000_0000, 2'b10};
        vecs[3]  = '{32'h8000_0000, 3'd3, 32'h0000_0000, 2'b10};
        vecs[4]  = '{32'h8000_1000, 3'd2, 32'h0000_0000, 2'b11};
        vecs[5]  = '{32'h7FFF_FFFC, 3'd2, 32'h0000_0000, 2'b11};
        vecs[6]  = '{32'h8000_1001, 3'd2, 32'h0000_0000, 2'b11};
        vecs[7]  = '{32'h8000_0FFC, 3'd2, 32'h1234_5678, 2'b00};
        vecs[8]  = '{32'h8000_0003, 3'd0, 32'hDEAD_BEEF, 2'b00};
        vecs[9]  = '{32'h8000_0006, 3'd2, 32'h0000_0000, 2'b10};
        vecs[10] = '{32'h8000_0004, 3'd2, 32'hAAAA_AAAA, 2'b00};

        rst = 1'b0; araddr = 32'h0; arvalid = 1'b0; arsize = 3'd2; rready = 1'b0;
        bd_wen = 1'b0; bd_waddr = 32'h0; bd_wdata = 32'h0; bd_wstrb = 4'h0;
        arvalid1 = 1'b0; rready1 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_arready", 32'(arready), 32'd1);

        bd_write(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
        bd_write(32'h8000_0004, 32'hAAAA_AAAA, 4'hF);
        bd_write(32'h8000_0008, 32'hCAFE_F00D, 4'hF);
        bd_write(32'h8000_000C, 32'hAAAA_AAAA, 4'hF);
        bd_write(32'h8000_0FFC, 32'h1234_5678, 4'hF);
        bd_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF);

        for (int i = 0; i < 11; i++) begin
            ar_read(vecs[i].addr, vecs[i].size, 1'b0, 32'h0, d, r, lat, hs, ara, rva);
            chk($sformatf("v%0d_rdata", i), d, vecs[i].data);
            chk($sformatf("v%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d_hs_arready", i), 32'(hs), 32'd1);
            chk($sformatf("v%0d_arready_after", i), 32'(ara), 32'd1);
            chk($sformatf("v%0d_rvalid_once", i), 32'(rva), 32'd0);
        end

        // Backpressure: rready low for 5 rvalid cycles, stray arvalid and a
        // backdoor write to the pending word must not disturb the response.
        @(posedge clk); #1;
        araddr = 32'h8000_0008; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_rvalid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("bp%0d_rvalid", i), 32'(rvalid), 32'd1);
            chk($sformatf("bp%0d_rdata", i), rdata, 32'hCAFE_F00D);
            chk($sformatf("bp%0d_rresp", i), 32'(rresp), 32'd0);
            chk($sformatf("bp%0d_arready", i), 32'(arready), 32'd0);
            @(posedge clk); #1;
            araddr = 32'h8000_0000;
            arvalid = (i == 1 || i == 3);
            rready = (i == 4);
            bd_wen = (i == 0); bd_waddr = 32'h8000_0008; bd_wdata = 32'h0; bd_wstrb = 4'hF;
        end
        @(negedge clk);
        chk("bp_release_rvalid", 32'(rvalid), 32'd1);
        chk("bp_release_rdata", rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        chk("bp_done_rvalid", 32'(rvalid), 32'd0);
        chk("bp_done_arready", 32'(arready), 32'd1);
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rvalid) quiet = 1'b0;
        end
        chk("bp_no_stray_accept", 32'(quiet), 32'd1);
        ar_read(32'h8000_0008, 3'd2, 1'b0, 32'h0, d, r, lat, hs, ara, rva);
        chk("bp_bd_write_landed", d, 32'h0);

        ar_read(32'h8000_0004, 3'd2, 1'b1, 32'h1111_1111, d, r, lat, hs, ara, rva);
        chk("rbw_old_data", d, 32'hAAAA_AAAA);
        ar_read(32'h8000_0004, 3'd2, 1'b0, 32'h0, d, r, lat, hs, ara, rva);
        chk("rbw_new_data", d, 32'h1111_1111);
        bd_write(32'h8000_000C, 32'h0000_5500, 4'b0010);
        ar_read(32'h8000_000C, 3'd2, 1'b0, 32'h0, d, r, lat, hs, ara, rva);
        chk("partial_strobe", d, 32'hAAAA_55AA);
        ar_read(32'h8000_0000, 3'd2, 1'b0, 32'h0, d, r, lat, hs, ara, rva);
        chk("oob_bd_dropped", d, 32'hDEAD_BEEF);

        // Reset while waiting aborts the response.
        @(posedge clk); #1;
        araddr = 32'h8000_0000; arsize = 3'd2; arvalid = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("wrst_arready_low", 32'(arready), 32'd0);
        chk("wrst_rvalid_low", 32'(rvalid), 32'd0);
        chk("wrst_rdata_zero", rdata, 32'h0);
        @(negedge clk);
        chk("wrst_arready_high", 32'(arready), 32'd1);
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rvalid) quiet = 1'b0;
        end
        chk("wrst_no_rvalid", 32'(quiet), 32'd1);

        // Zero-latency instance: rvalid in the cycle right after the handshake.
        @(posedge clk); #1;
        araddr = 32'h8000_0000; arsize = 3'd2; arvalid1 = 1'b1; rready1 = 1'b1;
        @(negedge clk);
        chk("lat0_hs_arready", 32'(arready1), 32'd1);
        chk("lat0_rvalid_T", 32'(rvalid1), 32'd0);
        @(posedge clk); #1;
        arvalid1 = 1'b0;
        @(negedge clk);
        chk("lat0_rvalid_T1", 32'(rvalid1), 32'd1);
        chk("lat0_rdata", rdata1, 32'hDEAD_BEEF);
        chk("lat0_rresp", 32'(rresp1), 32'd0);
        @(negedge clk);
        chk("lat0_rvalid_T2", 32'(rvalid1), 32'd0);
        chk("lat0_arready_T2", 32'(arready1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ysyx_25040129_rd_responder.md
Name: ysyx_25040129_rd_responder

Overview:
- Read-channel responder (subordinate) at the far end of the IFU/LSU read bus, downstream of the read arbiter.
- Accepts one AR request at a time and holds a word-addressed on-chip memory array.
- Returns the response after a programmable latency, flagging misaligned or out-of-range accesses.
- A backdoor write port preloads and updates the array.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of array word 0
- DEPTH, 1024, number of 32-bit words (power of two)
- LATENCY, 2, wait cycles between AR handshake and first rvalid cycle (0..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- araddr  in  32  read byte address
- arvalid  in  1  request valid
- arsize  in  3  log2 access bytes (0=byte, 1=half, 2=word)
- arready  out  1  request accepted when high with arvalid
- rdata  out  32  read data, full aligned word, byte lanes at natural positions
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rvalid  out  1  response valid
- rready  in  1  response accepted
- bd_wen  in  1  backdoor write enable
- bd_waddr  in  32  backdoor byte address, word-aligned; low 2 bits ignored
- bd_wdata  in  32  backdoor data
- bd_wstrb  in  4  byte enables for backdoor write

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, arready=0, rvalid=0, rresp=00, rdata=0, wait counter=0.
  - Array contents are not reset.
  - Reset aborts any pending or presenting response; no rvalid follows.
- arready=1 exactly when state=IDLE and rst=1. It is a registered function of state and carries no combinational path from arvalid.
- States:
  - IDLE: on arvalid&&arready (cycle T), latch rdata/rresp from the array and error checks, load counter=LATENCY. Go to WAIT, or to RESP if LATENCY=0.
  - WAIT: decrement counter each cycle; on the cycle the counter reaches 1, go to RESP. rvalid is first high at cycle T+1+LATENCY.
  - RESP: rvalid=1. rdata/rresp are held stable until rready. On rvalid&&rready, go to IDLE; arready=1 the following cycle.
  - Minimum spacing between successive AR handshakes is LATENCY+2 cycles.
- Error checks, evaluated on the AR handshake:
  - off = araddr - BASE_ADDR (32-bit wrap).
  - off>>2 >= DEPTH (unsigned) -> DECERR, rdata=0.
  - else arsize>2, or arsize=1 with araddr[0]=1, or arsize=2 with araddr[1:0]!=0 -> SLVERR, rdata=0.
  - else OKAY, rdata = mem[off>>2]. arsize does not shift or mask the data.
  - DECERR takes priority over SLVERR.
- Backdoor write:
  - When bd_wen=1 and rst=1, update mem[(bd_waddr-BASE_ADDR)>>2] byte-wise under bd_wstrb.
  - Out-of-range bd_waddr is silently dropped.
  - Accepted in any state.
- Same-cycle backdoor write and AR handshake to the same word: the read returns the old data (read-before-write).
- A backdoor write to the pending word during WAIT or RESP does not change the latched rdata.
- arvalid while not IDLE is ignored (arready=0). rready while rvalid=0 has no effect.

Test Plan:
- Preload mem[0]=32'hDEADBEEF via backdoor; AR araddr=8000_0000, arsize=2 at cycle T, rready held 1 -> rvalid high only in cycle T+3, rdata=DEADBEEF, rresp=00, arready high again at T+4.
- AR araddr=8000_0002, arsize=1 -> OKAY, rdata=full word mem[0]. AR araddr=8000_0001, arsize=1 -> rresp=10, rdata=0. AR arsize=3 at aligned address -> rresp=10.
- AR araddr=8000_1000 (DEPTH=1024) and araddr=7FFF_FFFC -> rresp=11, rdata=0. Misaligned out-of-range address 8000_1001 with arsize=2 -> rresp=11.
- Backpressure: rready=0 for 5 cycles after rvalid -> rvalid, rdata, rresp stable all 5 cycles; arready=0 throughout; arvalid pulses in this window are not accepted.
- Backdoor write mem[1]=1111_1111 in the same cycle as an AR to 8000_0004 (old value AAAA_AAAA) -> returns AAAA_AAAA. A next read -> 1111_1111. Partial write with wstrb=0010, wdata=0000_5500 -> word AAAA_55AA.
- Drive rst=0 for one cycle while in WAIT -> no rvalid appears, arready=0 in the reset cycle and 1 on the next cycle. With LATENCY=0, rvalid is asserted at T+1.
